// File: rtl/run_sequencer_pkg.sv
// Shared constants for the inference run sequencer: state encodings,
// status byte layout and SPI write-enable bit indices.
package run_sequencer_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    localparam int STATUS_ERR_TIMEOUT   = 7;
    localparam int STATUS_ERR_EXT_WRITE = 6;
    localparam int STATUS_DONE          = 5;
    localparam int STATUS_BUSY          = 4;

    localparam int WREN_ACT   = 0;
    localparam int WREN_PARAM = 1;
    localparam int WREN_INST  = 2;

    // Assemble the SPI-readable status byte; bit 3 is reserved and reads 0.
    function automatic logic [7:0] pack_status(
        input logic       err_timeout,
        input logic       err_ext_write,
        input logic       done_flag,
        input logic       busy,
        input logic [2:0] state
    );
        logic [7:0] s;
        s                       = 8'h00;
        s[STATUS_ERR_TIMEOUT]   = err_timeout;
        s[STATUS_ERR_EXT_WRITE] = err_ext_write;
        s[STATUS_DONE]          = done_flag;
        s[STATUS_BUSY]          = busy;
        s[2:0]                  = state;
        return s;
    endfunction

endpackage

// File: rtl/run_sequencer_guard_timer.sv
// Loadable down-counter with a zero flag. Times the mux-settling windows
// on both ownership hand-overs (ARM and DRAIN).
module guard_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_r;

    // Load has priority over counting; the count parks at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != '0)) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == '0);

endmodule

// File: rtl/run_sequencer.sv
// Sequences one processor inference run and owns the memory-port select
// between the SPI loader and the processor.
module run_sequencer
    import run_sequencer_pkg::*;
#(
    parameter int unsigned          GUARD_CYCLES   = 2,
    parameter int unsigned          TIMEOUT_W      = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'hFFFFFF,
    parameter int unsigned          LAYER_CNT_W    = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   proc_done,
    input  logic                   proc_done_layer,
    input  logic [2:0]             ext_wren_in,
    output logic [2:0]             ext_wren_out,
    output logic                   sel_ext,
    output logic                   proc_en,
    output logic                   proc_rst_n,
    output logic                   busy,
    output logic                   done_flag,
    output logic                   err_timeout,
    output logic                   err_ext_write,
    output logic [LAYER_CNT_W-1:0] layer_count,
    output logic [7:0]             status
);

    // The guard timer is loaded with GUARD_CYCLES-1 so that the state is
    // held for exactly GUARD_CYCLES cycles (it leaves on the zero flag).
    localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GUARD_W-1:0]   GUARD_LOAD = GUARD_W'(GUARD_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] WD_LAST    = TIMEOUT_CYCLES - TIMEOUT_W'(1);

    logic [2:0]             state_r, state_nx_s;
    logic                   start_q_r, start_armed_r, start_edge_s;
    logic                   guard_load_s, guard_dec_s, guard_zero_s;
    logic [TIMEOUT_W-1:0]   wd_r;
    logic                   wd_expire_s, clear_s;
    logic                   sel_ext_r, proc_en_r, proc_rst_n_r, busy_r;
    logic                   sel_ext_nx_s, proc_en_nx_s, proc_rst_n_nx_s, busy_nx_s;
    logic                   done_flag_r, err_timeout_r, err_ext_write_r;
    logic                   done_flag_nx_s, err_timeout_nx_s, err_ext_write_nx_s;
    logic [LAYER_CNT_W-1:0] layer_count_r, layer_count_nx_s;

    // A start level already high when reset releases is not a request:
    // start_armed_r only opens once start has been seen low.
    assign start_edge_s = start & ~start_q_r & start_armed_r;
    assign wd_expire_s  = (TIMEOUT_CYCLES != '0) && (wd_r == WD_LAST);
    assign clear_s      = abort | ((state_nx_s == ST_ARM) && (state_r != ST_ARM));

    guard_timer #(.W(GUARD_W)) u_guard (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (guard_load_s),
        .load_val (GUARD_LOAD),
        .dec      (guard_dec_s),
        .zero     (guard_zero_s)
    );

    // Next-state logic; abort overrides everything, proc_done beats the watchdog.
    always_comb begin
        state_nx_s   = state_r;
        guard_load_s = 1'b0;
        guard_dec_s  = 1'b0;
        if (abort) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_edge_s) begin
                        state_nx_s   = ST_ARM;
                        guard_load_s = 1'b1;
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                ST_ARM: begin
                    if (guard_zero_s) begin
                        state_nx_s = ST_RUN;
                    end else begin
                        guard_dec_s = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (proc_done) begin
                        state_nx_s   = ST_DRAIN;
                        guard_load_s = 1'b1;
                    end else if (wd_expire_s) begin
                        state_nx_s = ST_ERR;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (guard_zero_s) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        guard_dec_s = 1'b1;
                    end
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Moore output decode from the next state so outputs register with the state.
    always_comb begin
        sel_ext_nx_s    = 1'b1;
        proc_en_nx_s    = 1'b0;
        proc_rst_n_nx_s = 1'b1;
        busy_nx_s       = 1'b0;
        case (state_nx_s)
            ST_ARM: begin
                sel_ext_nx_s    = 1'b0;
                proc_rst_n_nx_s = 1'b0;
                busy_nx_s       = 1'b1;
            end
            ST_RUN: begin
                sel_ext_nx_s = 1'b0;
                proc_en_nx_s = 1'b1;
                busy_nx_s    = 1'b1;
            end
            ST_DRAIN: begin
                sel_ext_nx_s = 1'b0;
                busy_nx_s    = 1'b1;
            end
            default: begin
                sel_ext_nx_s = 1'b1;
            end
        endcase
    end

    // Sticky flags and layer counter; a new run or an abort clears them all.
    always_comb begin
        done_flag_nx_s     = done_flag_r;
        err_timeout_nx_s   = err_timeout_r;
        err_ext_write_nx_s = err_ext_write_r;
        layer_count_nx_s   = layer_count_r;
        if (clear_s) begin
            done_flag_nx_s     = 1'b0;
            err_timeout_nx_s   = 1'b0;
            err_ext_write_nx_s = 1'b0;
            layer_count_nx_s   = '0;
        end else begin
            if (state_nx_s == ST_DONE) begin
                done_flag_nx_s = 1'b1;
            end else begin
                done_flag_nx_s = done_flag_r;
            end
            if (state_nx_s == ST_ERR) begin
                err_timeout_nx_s = 1'b1;
            end else begin
                err_timeout_nx_s = err_timeout_r;
            end
            if ((|ext_wren_in) && !sel_ext_r) begin
                err_ext_write_nx_s = 1'b1;
            end else begin
                err_ext_write_nx_s = err_ext_write_r;
            end
            if ((state_r == ST_RUN) && proc_done_layer && (layer_count_r != '1)) begin
                layer_count_nx_s = layer_count_r + LAYER_CNT_W'(1);
            end else begin
                layer_count_nx_s = layer_count_r;
            end
        end
    end

    // Start history for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_q_r     <= 1'b0;
            start_armed_r <= 1'b0;
        end else begin
            start_q_r     <= start;
            start_armed_r <= start_armed_r | ~start;
        end
    end

    // Run watchdog: counts consecutive RUN cycles, zero elsewhere.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_r <= '0;
        end else if ((state_r == ST_RUN) && (state_nx_s == ST_RUN)) begin
            wd_r <= wd_r + TIMEOUT_W'(1);
        end else begin
            wd_r <= '0;
        end
    end

    // State, registered outputs and flags; reset hands memories back to SPI.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            sel_ext_r       <= 1'b1;
            proc_en_r       <= 1'b0;
            proc_rst_n_r    <= 1'b0;
            busy_r          <= 1'b0;
            done_flag_r     <= 1'b0;
            err_timeout_r   <= 1'b0;
            err_ext_write_r <= 1'b0;
            layer_count_r   <= '0;
        end else begin
            state_r         <= state_nx_s;
            sel_ext_r       <= sel_ext_nx_s;
            proc_en_r       <= proc_en_nx_s;
            proc_rst_n_r    <= proc_rst_n_nx_s;
            busy_r          <= busy_nx_s;
            done_flag_r     <= done_flag_nx_s;
            err_timeout_r   <= err_timeout_nx_s;
            err_ext_write_r <= err_ext_write_nx_s;
            layer_count_r   <= layer_count_nx_s;
        end
    end

    assign ext_wren_out[WREN_ACT]   = ext_wren_in[WREN_ACT]   & sel_ext_r;
    assign ext_wren_out[WREN_PARAM] = ext_wren_in[WREN_PARAM] & sel_ext_r;
    assign ext_wren_out[WREN_INST]  = ext_wren_in[WREN_INST]  & sel_ext_r;

    assign sel_ext       = sel_ext_r;
    assign proc_en       = proc_en_r;
    assign proc_rst_n    = proc_rst_n_r;
    assign busy          = busy_r;
    assign done_flag     = done_flag_r;
    assign err_timeout   = err_timeout_r;
    assign err_ext_write = err_ext_write_r;
    assign layer_count   = layer_count_r;
    assign status        = pack_status(err_timeout_r, err_ext_write_r, done_flag_r, busy_r, state_r);

endmodule

// File: tb/tb_run_sequencer.sv
// Directed, table-driven bench for run_sequencer (GUARD=2, TIMEOUT=100, 6-bit layers).
module tb_run_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, abort, proc_done, proc_done_layer;
    logic [2:0] ext_wren_in, ext_wren_out;
    logic       sel_ext, proc_en, proc_rst_n, busy;
    logic       done_flag, err_timeout, err_ext_write;
    logic [5:0] layer_count;
    logic [7:0] status;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       st;
        logic       ab;
        logic       dn;
        logic       ly;
        logic [2:0] wr;
        logic       sel;
        logic       en;
        logic       rstn;
        logic [7:0] stat;
        logic [5:0] lc;
        logic [2:0] wout;
    } vec_t;

    vec_t vecs[$];

    run_sequencer #(
        .GUARD_CYCLES   (2),
        .TIMEOUT_W      (24),
        .TIMEOUT_CYCLES (24'd100),
        .LAYER_CNT_W    (6)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .abort           (abort),
        .proc_done       (proc_done),
        .proc_done_layer (proc_done_layer),
        .ext_wren_in     (ext_wren_in),
        .ext_wren_out    (ext_wren_out),
        .sel_ext         (sel_ext),
        .proc_en         (proc_en),
        .proc_rst_n      (proc_rst_n),
        .busy            (busy),
        .done_flag       (done_flag),
        .err_timeout     (err_timeout),
        .err_ext_write   (err_ext_write),
        .layer_count     (layer_count),
        .status          (status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic st, input logic ab, input logic dn, input logic ly,
                       input logic [2:0] wr, input logic sel, input logic en, input logic rstn,
                       input logic [7:0] stat, input logic [5:0] lc, input logic [2:0] wout);
        vec_t v;
        v = '{st, ab, dn, ly, wr, sel, en, rstn, stat, lc, wout};
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        //  st    ab    dn    ly    wr      sel   en    rstn  status lc     wout
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 8'h00, 6'd0, 3'b000); // 0 idle
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 8'h00, 6'd0, 3'b000);
        add(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'h11, 6'd0, 3'b000); // 2 arm
        add(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'h11, 6'd0, 3'b000);
        add(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 8'h12, 6'd0, 3'b000); // 4 run
        add(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 8'h12, 6'd1, 3'b000);
        add(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 8'h12, 6'd1, 3'b000);
        add(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 8'h12, 6'd2, 3'b000);
        add(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 8'h12, 6'd3, 3'b000);
        add(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 8'h13, 6'd3, 3'b000); // 9 drain
        add(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 8'h13, 6'd3, 3'b000);
        add(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 8'h24, 6'd3, 3'b000); // 11 done
        add(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 8'h24, 6'd3, 3'b000);
        add(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 8'h24, 6'd3, 3'b000);
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 8'h24, 6'd3, 3'b001); // 14 write passes
        add(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'h11, 6'd0, 3'b000); // 15 rerun clears
        add(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 8'h00, 6'd0, 3'b000); // 16 abort in arm
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 8'h00, 6'd0, 3'b000);
        add(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'h11, 6'd0, 3'b000);
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'h11, 6'd0, 3'b000);
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 8'h12, 6'd0, 3'b000); // 20 run
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1, 1'b1, 8'h52, 6'd0, 3'b000); // 21 blocked write
        add(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 8'h52, 6'd1, 3'b000);
        add(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 8'h00, 6'd0, 3'b000); // 23 abort+start
        add(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 8'h00, 6'd0, 3'b000);
        add(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 8'h00, 6'd0, 3'b000); // 25 held, no run
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 8'h00, 6'd0, 3'b000);
        add(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'h11, 6'd0, 3'b000);
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'h11, 6'd0, 3'b000);
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 8'h12, 6'd0, 3'b000);
        add(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 8'h13, 6'd1, 3'b000); // 30 done+layer
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 8'h13, 6'd1, 3'b000);
        add(1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0, 1'b1, 8'h64, 6'd1, 3'b100); // 32 drain write
        add(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 8'h00, 6'd0, 3'b000); // 33 abort from done

        reset_n = 1'b0;
        start = 1'b0; abort = 1'b0; proc_done = 1'b0; proc_done_layer = 1'b0;
        ext_wren_in = 3'b001;
        step();
        step();
        chk("rst_sel_ext",    32'(sel_ext),      32'(1'b1));
        chk("rst_proc_en",    32'(proc_en),      32'(1'b0));
        chk("rst_proc_rst_n", 32'(proc_rst_n),   32'(1'b0));
        chk("rst_status",     32'(status),       32'(8'h00));
        chk("rst_layer",      32'(layer_count),  32'(6'd0));
        chk("rst_wren_out",   32'(ext_wren_out), 32'(3'b001));
        ext_wren_in = 3'b000;
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            start           = vecs[i].st;
            abort           = vecs[i].ab;
            proc_done       = vecs[i].dn;
            proc_done_layer = vecs[i].ly;
            ext_wren_in     = vecs[i].wr;
            step();
            chk($sformatf("v%0d_sel_ext", i),    32'(sel_ext),      32'(vecs[i].sel));
            chk($sformatf("v%0d_proc_en", i),    32'(proc_en),      32'(vecs[i].en));
            chk($sformatf("v%0d_proc_rst_n", i), 32'(proc_rst_n),   32'(vecs[i].rstn));
            chk($sformatf("v%0d_status", i),     32'(status),       32'(vecs[i].stat));
            chk($sformatf("v%0d_layer", i),      32'(layer_count),  32'(vecs[i].lc));
            chk($sformatf("v%0d_wren_out", i),   32'(ext_wren_out), 32'(vecs[i].wout));
        end
        abort = 1'b0; proc_done = 1'b0; proc_done_layer = 1'b0; ext_wren_in = 3'b000;

        // Watchdog timeout: proc_en must be high for exactly 100 cycles.
        begin
            int n;
            n = 0;
            start = 1'b1;
            step();
            for (int k = 0; k < 200; k++) begin
                step();
                if (proc_en) begin
                    n++;
                end else if (n > 0) begin
                    break;
                end
            end
            chk("to_en_cycles",  32'(n),           32'd100);
            chk("to_status",     32'(status),      32'(8'h85));
            chk("to_sel_ext",    32'(sel_ext),     32'(1'b1));
            chk("to_err",        32'(err_timeout), 32'(1'b1));
            start = 1'b0;
            step();
            chk("to_hold",       32'(status),      32'(8'h85));
            start = 1'b1;
            step();
            chk("to_restart",    32'(status),      32'(8'h11));
            abort = 1'b1;
            step();
            abort = 1'b0;
            start = 1'b0;
            step();
            chk("to_abort_idle", 32'(status),      32'(8'h00));
        end

        // proc_done on the watchdog's last cycle, plus layer saturation.
        start = 1'b1;
        step();
        step();
        step();
        chk("sat_run", 32'(status), 32'(8'h12));
        for (int k = 1; k <= 100; k++) begin
            proc_done_layer = (k <= 70);
            proc_done       = (k == 100);
            step();
            if (k == 63) chk("sat_layer63", 32'(layer_count), 32'(6'd63));
            if (k == 99) chk("sat_still_run", 32'(status), 32'(8'h12));
        end
        proc_done_layer = 1'b0;
        proc_done       = 1'b0;
        chk("sat_drain_status", 32'(status),      32'(8'h13));
        chk("sat_layer",        32'(layer_count), 32'(6'd63));
        chk("sat_proc_en",      32'(proc_en),     32'(1'b0));

        // Asynchronous reset mid-DRAIN with start held high.
        reset_n = 1'b0;
        ext_wren_in = 3'b010;
        #2;
        chk("arst_sel_ext",    32'(sel_ext),      32'(1'b1));
        chk("arst_proc_en",    32'(proc_en),      32'(1'b0));
        chk("arst_proc_rst_n", 32'(proc_rst_n),   32'(1'b0));
        chk("arst_status",     32'(status),       32'(8'h00));
        chk("arst_layer",      32'(layer_count),  32'(6'd0));
        chk("arst_wren_out",   32'(ext_wren_out), 32'(3'b010));
        reset_n = 1'b1;
        ext_wren_in = 3'b000;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("arst_held_%0d", k), 32'(status), 32'(8'h00));
        end
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        chk("arst_new_run", 32'(status), 32'(8'h11));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
